// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier for the EX-stage MUL operation.
// Stalls the pipeline while iterating, then presents the low WIDTH product bits for one cycle.
`timescale 1ns/1ps

module mul_sequencer #(
   parameter int unsigned WIDTH    = 32,
   parameter logic [2:0]  MUL_CODE = 3'd4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic [2:0]       ALUCtrl_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             stall_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int unsigned   CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;

   logic             mul_go_s;
   logic [WIDTH-1:0] acc_sum_s;

   assign mul_go_s  = req_i && (ALUCtrl_i == MUL_CODE) && !flush_i;
   assign acc_sum_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // Next-state and datapath update for the sequencing FSM
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mul_go_s) begin
               mcand_d  = data1_i;
               mplier_d = data2_i;
               acc_d    = {WIDTH{1'b0}};
               count_d  = {CW{1'b0}};
               state_d  = BUSY;
            end else begin
               state_d  = IDLE;
            end
         end
         BUSY: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               acc_d    = acc_sum_s;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               count_d  = count_q + {{(CW-1){1'b0}}, 1'b1};
               // The last iteration's add is folded straight into the result
               if (count_q == LAST) begin
                  state_d  = DONE;
                  result_d = acc_sum_s;
                  valid_d  = 1'b1;
               end else begin
                  state_d  = BUSY;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         count_q  <= {CW{1'b0}};
         acc_q    <= {WIDTH{1'b0}};
         mcand_q  <= {WIDTH{1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         result_q <= {WIDTH{1'b0}};
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   // A flush squashes the DONE pulse and releases the stall in the same cycle
   assign stall_o  = rst_i && (((state_q == IDLE) && mul_go_s) ||
                               ((state_q == BUSY) && !flush_i));
   assign valid_o  = valid_q && !flush_i;
   assign result_o = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: vector table, scoreboard queue and multi-cycle corner sequences.
`timescale 1ns/1ps

module tb_mul_sequencer;

   localparam int W = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          req_i;
   logic [2:0]    ALUCtrl_i;
   logic          flush_i;
   logic [W-1:0]  data1_i;
   logic [W-1:0]  data2_i;
   logic          stall_o;
   logic          valid_o;
   logic [W-1:0]  result_o;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] p;
   } vec_t;

   vec_t vecs[6];

   mul_sequencer #(.WIDTH(W), .MUL_CODE(3'd4)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .ALUCtrl_i (ALUCtrl_i),
      .flush_i   (flush_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .stall_o   (stall_o),
      .valid_o   (valid_o),
      .result_o  (result_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every valid_o pulse must match the oldest outstanding product
   always @(negedge clk_i) begin
      if (valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid: got result %h with no product expected", result_o);
         end else begin
            check("sb_result", result_o, exp_q.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      req_i     = 1'b0;
      flush_i   = 1'b0;
      ALUCtrl_i = 3'd0;
      repeat (n) begin
         @(negedge clk_i);
         check("idle_stall", W'(stall_o), W'(0));
         check("idle_valid", W'(valid_o), W'(0));
         @(posedge clk_i);
         #1;
      end
   endtask

   // Issue one MUL at cycle T and hold it in EX (as a stalled pipeline would) through DONE
   task automatic mul_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p);
      exp_q.push_back(p);
      req_i     = 1'b1;
      ALUCtrl_i = 3'd4;
      flush_i   = 1'b0;
      data1_i   = a;
      data2_i   = b;
      for (int k = 0; k <= W + 1; k++) begin
         @(negedge clk_i);
         check($sformatf("mul_stall_T%0d", k), W'(stall_o), W'(k <= W));
         check($sformatf("mul_valid_T%0d", k), W'(valid_o), W'(k == W + 1));
         @(posedge clk_i);
         #1;
         data1_i = $urandom;
         data2_i = $urandom;
      end
   endtask

   initial begin
      rst_i     = 1'b0;
      req_i     = 1'b0;
      ALUCtrl_i = 3'd0;
      flush_i   = 1'b0;
      data1_i   = '0;
      data2_i   = '0;

      vecs[0] = '{a: 32'd7,          b: 32'd6,          p: 32'd42};
      vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 32'h0000_0001};
      vecs[2] = '{a: 32'h8000_0000,  b: 32'd2,          p: 32'h0000_0000};
      vecs[3] = '{a: 32'h1234_5678,  b: 32'd0,          p: 32'h0000_0000};
      vecs[4] = '{a: 32'd0,          b: 32'hDEAD_BEEF,  p: 32'h0000_0000};
      vecs[5].a = $urandom;
      vecs[5].b = $urandom;
      vecs[5].p = vecs[5].a * vecs[5].b;

      // Reset state, with a MUL request pending so stall_o must be forced low
      req_i     = 1'b1;
      ALUCtrl_i = 3'd4;
      #12;
      check("reset_stall",  W'(stall_o), W'(0));
      check("reset_valid",  W'(valid_o), W'(0));
      check("reset_result", result_o, W'(0));
      @(negedge clk_i);
      req_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      idle(2);

      for (int i = 0; i < 6; i++) begin
         mul_op(vecs[i].a, vecs[i].b, vecs[i].p);
         idle(2);
      end

      // Back-to-back: second MUL enters EX the cycle after DONE
      mul_op(32'd3, 32'd5, 32'd15);
      mul_op(32'd9, 32'd9, 32'd81);
      idle(3);

      // Flush at T+10 aborts the operation; result keeps 81
      req_i     = 1'b1;
      ALUCtrl_i = 3'd4;
      data1_i   = 32'd3;
      data2_i   = 32'd5;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         check("flush_pre_stall", W'(stall_o), W'(1));
         @(posedge clk_i);
         #1;
      end
      flush_i = 1'b1;
      @(negedge clk_i);
      check("flush_stall", W'(stall_o), W'(0));
      check("flush_valid", W'(valid_o), W'(0));
      @(posedge clk_i);
      #1;
      idle(40);
      check("flush_result_held", result_o, 32'd81);
      mul_op(32'd4, 32'd4, 32'd16);
      idle(2);

      // Bypass: non-MUL codes never stall or complete
      for (int c = 0; c < 4; c++) begin
         req_i     = 1'b1;
         ALUCtrl_i = 3'(c);
         data1_i   = 32'd100;
         data2_i   = 32'd200;
         for (int k = 0; k < 36; k++) begin
            @(negedge clk_i);
            check("bypass_stall", W'(stall_o), W'(0));
            check("bypass_valid", W'(valid_o), W'(0));
            @(posedge clk_i);
            #1;
         end
      end
      check("bypass_result_held", result_o, 32'd16);
      idle(2);

      // Reset mid-BUSY: outputs clear immediately and no completion follows
      req_i     = 1'b1;
      ALUCtrl_i = 3'd4;
      data1_i   = 32'd11;
      data2_i   = 32'd13;
      repeat (10) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      #1;
      check("midrst_stall",  W'(stall_o), W'(0));
      check("midrst_valid",  W'(valid_o), W'(0));
      check("midrst_result", result_o, W'(0));
      repeat (3) begin
         @(negedge clk_i);
         check("inrst_stall", W'(stall_o), W'(0));
      end
      req_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      idle(40);
      check("postrst_result", result_o, W'(0));
      mul_op(32'd11, 32'd13, 32'd143);
      idle(3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d outstanding products expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
